// File: rtl/carry_save_accum.sv
// Carry-save accumulator: groups of operands are summed in redundant S/C form.
// A chunked carry-propagate pass then resolves the sum and hands it off.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   operand handshake (in_data, in_last)
//   out_valid/out_ready result handshake (out_sum, out_count)
module carry_save_accum #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [7:0]       out_count
);

    localparam int N  = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
        $error("carry_save_accum: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic [7:0]       cnt;
    logic [KW-1:0]    k;
    logic             cy;

    logic [WIDTH-1:0] s_nxt;
    logic [WIDTH-1:0] c_nxt;
    logic [7:0]       cnt_nxt;
    logic [CHUNK-1:0] s_chk;
    logic [CHUNK-1:0] c_chk;
    logic [CHUNK:0]   csum;

    // Only the state decides acceptance; reset lands in ACCUM,
    // so in_ready is high during and after reset.
    assign in_ready = (state == ACCUM);

    // 3:2 compression of S, C and the new operand.
    always_comb begin
        s_nxt = s_q ^ c_q ^ in_data;
        c_nxt = ((s_q & c_q) | (s_q & in_data) | (c_q & in_data)) << 1;
    end

    assign cnt_nxt = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

    // Select chunk k of S and C for the carry-propagate pass.
    always_comb begin
        s_chk = '0;
        c_chk = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                s_chk = s_q[i*CHUNK +: CHUNK];
                c_chk = c_q[i*CHUNK +: CHUNK];
            end
        end
        csum = {1'b0, s_chk} + {1'b0, c_chk} + {{CHUNK{1'b0}}, cy};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            s_q       <= '0;
            c_q       <= '0;
            cnt       <= '0;
            k         <= '0;
            cy        <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (in_valid) begin
                        s_q <= s_nxt;
                        c_q <= c_nxt;
                        cnt <= cnt_nxt;
                        if (in_last) begin
                            out_count <= cnt_nxt;
                            k         <= '0;
                            cy        <= 1'b0;
                            state     <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    for (int i = 0; i < N; i++) begin
                        if (k == KW'(i)) begin
                            out_sum[i*CHUNK +: CHUNK] <= csum[CHUNK-1:0];
                        end
                    end
                    cy <= csum[CHUNK];
                    // Carry out of the top chunk is dropped: modulo sum.
                    if (k == KW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        s_q       <= '0;
                        c_q       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carry_save_accum.sv
// Bench for carry_save_accum: vector table, corner sequences, random groups.
// Expected sums come from plain modular arithmetic.
module tb_carry_save_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic [7:0]  out_count;

    int vecs;
    int errs;

    carry_save_accum #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [15:0] op [3];
        logic [15:0] esum;
        logic [7:0]  ecnt;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Present one operand and let one rising edge take it.
    task automatic send(input logic [15:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called #1 after the last-accept edge (edge 1).
    task automatic wait_done(input string name, input logic [15:0] es,
                             input logic [7:0] ec);
        int edges;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check({name, " valid"}, 32'(out_valid), 32'd1);
        check({name, " latency"}, 32'(edges), 32'd5);
        check({name, " sum"}, 32'(out_sum), 32'(es));
        check({name, " count"}, 32'(out_count), 32'(ec));
    endtask

    task automatic ack(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " valid after ack"}, 32'(out_valid), 32'd0);
        check({name, " ready after ack"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] msum;
        int          mcnt;
        int          len;
        logic [15:0] d;

        vecs      = 0;
        errs      = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{3, '{16'h1234, 16'h1111, 16'h0001}, 16'h2346, 8'd3};
        tbl[1] = '{2, '{16'hFFFF, 16'h0001, 16'h0000}, 16'h0000, 8'd2};
        tbl[2] = '{1, '{16'hABCD, 16'h0000, 16'h0000}, 16'hABCD, 8'd1};
        tbl[3] = '{3, '{16'h8000, 16'h8000, 16'h7FFF}, 16'h7FFF, 8'd3};
        tbl[4] = '{3, '{16'h0FFF, 16'h0001, 16'hF000}, 16'h0000, 8'd3};

        // Reset state before any clock edge.
        #3;
        check("rst valid", 32'(out_valid), 32'd0);
        check("rst sum", 32'(out_sum), 32'd0);
        check("rst count", 32'(out_count), 32'd0);
        check("rst ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[v]) begin
            for (int j = 0; j < tbl[v].n; j++)
                send(tbl[v].op[j], j == tbl[v].n - 1);
            wait_done($sformatf("tbl%0d", v), tbl[v].esum, tbl[v].ecnt);
            ack($sformatf("tbl%0d", v));
        end

        // Async reset mid-cycle while DONE holds a result.
        send(16'h4321, 1'b1);
        wait_done("pre-rst", 16'h4321, 8'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 32'(out_valid), 32'd0);
        check("arst sum", 32'(out_sum), 32'd0);
        check("arst count", 32'(out_count), 32'd0);
        check("arst ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Backpressure in DONE with in_valid asserted.
        send(16'h0100, 1'b0);
        send(16'h0200, 1'b1);
        wait_done("bp", 16'h0300, 8'd2);
        in_valid = 1'b1;
        in_data  = 16'h7777;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("bp hold sum", 32'(out_sum), 32'h0300);
            check("bp hold count", 32'(out_count), 32'd2);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        ack("bp");
        send(16'h0009, 1'b1);
        wait_done("bp next", 16'h0009, 8'd1);
        ack("bp next");

        // Count saturation.
        for (int i = 1; i <= 300; i++)
            send(16'h0001, i == 300);
        wait_done("sat", 16'h012C, 8'd255);
        ack("sat");

        // Reset two cycles into RESOLVE abandons the group.
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst valid", 32'(out_valid), 32'd0);
        check("mid rst ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0005, 1'b1);
        wait_done("mid rst", 16'h0005, 8'd1);
        ack("mid rst");

        // Random groups against a modular-sum model.
        for (int g = 0; g < 25; g++) begin
            msum = '0;
            mcnt = 0;
            len  = int'($urandom_range(1, 6));
            for (int j = 0; j < len; j++) begin
                d    = 16'($urandom);
                msum = msum + d;
                mcnt = mcnt + 1;
                send(d, j == len - 1);
            end
            wait_done($sformatf("rnd%0d", g), msum, 8'(mcnt));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
                check("rnd hold", 32'(out_sum), 32'(msum));
            end
            ack($sformatf("rnd%0d", g));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
